// File: rtl/qif_pkg.sv
// qif_pkg: shared defaults, event record type and saturation helper for the QIF neuron array.
//   QIF_*        default parameter values used by qif_neuron_array and qif_evt_fifo
//   qif_event_t  {ch, ts} event record at the default channel/timestamp widths
//   sat_w        clamp a signed 64-bit value to the signed range of a w-bit word
package qif_pkg;

   localparam int QIF_W        = 8;
   localparam int QIF_N_CH     = 4;
   localparam int QIF_V_TH     = 50;
   localparam int QIF_V_RESET  = -20;
   localparam int QIF_REFRAC   = 2;
   localparam int QIF_I_SHIFT  = 2;
   localparam int QIF_Q_SHIFT  = 3;
   localparam int QIF_EV_DEPTH = 4;
   localparam int QIF_TS_W     = 16;
   localparam int QIF_CW       = (QIF_N_CH > 1) ? $clog2(QIF_N_CH) : 1;

   typedef struct packed {
      logic [QIF_CW-1:0]   ch;
      logic [QIF_TS_W-1:0] ts;
   } qif_event_t;

   function automatic logic signed [63:0] sat_w(input logic signed [63:0] x, input int w);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      return (x > hi) ? hi : (x < lo) ? lo : x;
   endfunction

endpackage

// File: rtl/qif_evt_fifo.sv
// qif_evt_fifo: synchronous event FIFO with simultaneous push/pop, including at full.
//   clk, rst_n      clock; asynchronous active-high reset (empties the FIFO)
//   push, push_data write request and payload (ignored when full unless popping)
//   pop             read request (ignored when empty)
//   head            oldest entry, valid while !empty
//   count           number of stored entries, 0..DEPTH
//   full, empty     occupancy flags
module qif_evt_fifo
   import qif_pkg::*;
#(
   parameter type T     = qif_event_t,
   parameter int  DEPTH = QIF_EV_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  T            push_data,
   input  logic        pop,
   output T            head,
   output logic [AW:0] count,
   output logic        full,
   output logic        empty
);

   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   T              mem [DEPTH];
   logic [AW-1:0] wp;
   logic [AW-1:0] rp;
   logic          wr;
   logic          rd;

   // At full with a pop, wp equals rp: the new entry lands in the slot being vacated.
   always_comb begin
      full  = count == FULL_CNT;
      empty = count == '0;
      wr    = push && (!full || pop);
      rd    = pop && !empty;
      head  = mem[rp];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         if (wr) wp <= wp + AW'(1);
         if (rd) rp <= rp + AW'(1);
         count <= count + (AW+1)'(wr) - (AW+1)'(rd);
      end
   end

   always_ff @(posedge clk) begin
      if (wr) mem[wp] <= push_data;
   end

endmodule

// File: rtl/qif_neuron_array.sv
// qif_neuron_array: N_CH time-multiplexed quadratic integrate-and-fire neurons on one saturating datapath.
//   clk, rst_n                  clock; asynchronous active-high reset
//   i_valid/i_ready/i_ch/i_syn  update request: channel and signed synaptic current
//   v_valid/v_ch/v_mem/v_spike  one-cycle result pulse: channel, new membrane value, fired flag
//   ev_valid/ev_ready/ev_ch/ev_ts  spike event FIFO read port (head channel and timestamp)
//   ev_drop                     saturating count of events lost to a full FIFO
// Build option QIF_EVT_BACKPRESSURE_EN: throttle i_ready so every in-flight spike
// is guaranteed FIFO space; otherwise i_ready is tied high and overflow drops events.
module qif_neuron_array
   import qif_pkg::*;
#(
   parameter int  W        = QIF_W,
   parameter int  N_CH     = QIF_N_CH,
   parameter int  V_TH     = QIF_V_TH,
   parameter int  V_RESET  = QIF_V_RESET,
   parameter int  REFRAC   = QIF_REFRAC,
   parameter int  I_SHIFT  = QIF_I_SHIFT,
   parameter int  Q_SHIFT  = QIF_Q_SHIFT,
   parameter int  EV_DEPTH = QIF_EV_DEPTH,
   parameter int  TS_W     = QIF_TS_W,
   localparam int CW       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_valid,
   output logic                i_ready,
   input  logic [CW-1:0]       i_ch,
   input  logic signed [W-1:0] i_syn,
   output logic                v_valid,
   output logic [CW-1:0]       v_ch,
   output logic signed [W-1:0] v_mem,
   output logic                v_spike,
   output logic                ev_valid,
   input  logic                ev_ready,
   output logic [CW-1:0]       ev_ch,
   output logic [TS_W-1:0]     ev_ts,
   output logic [7:0]          ev_drop
);

   localparam int SW = 2 * W + 2;
   localparam int AW = $clog2(EV_DEPTH);
   localparam logic signed [W-1:0] VTH = V_TH[W-1:0];
   localparam logic signed [W-1:0] VR  = V_RESET[W-1:0];
   localparam logic [3:0]          RF  = REFRAC[3:0];
   localparam logic [CW:0]         NCH = (CW+1)'(N_CH);

   typedef struct packed {
      logic [CW-1:0]   ch;
      logic [TS_W-1:0] ts;
   } ev_t;

   logic signed [W-1:0] v_q [N_CH];
   logic [3:0]          r_q [N_CH];

   logic                s1_valid;
   logic [CW-1:0]       s1_ch;
   logic signed [W-1:0] s1_syn;

   logic signed [W-1:0]  v_cur;
   logic signed [W-1:0]  syn_sh;
   logic signed [W-1:0]  q_sh;
   logic signed [W-1:0]  v_sat;
   logic signed [W-1:0]  v_nxt;
   logic signed [SW-1:0] sum;
   logic [3:0]           r_cur;
   logic [3:0]           r_nxt;
   logic                 ch_ok;
   logic                 at_th;
   logic                 upd;
   logic                 fire;

   logic [TS_W-1:0] ts;
   ev_t             ev_in;
   ev_t             ev_head;
   logic [AW:0]     ev_count;
   logic            ev_full;
   logic            ev_empty;
   logic            ev_push;
   logic            ev_pop;
   logic            drop;

   // S1 compute: refractory hold beats threshold test, which beats integration.
   // The threshold is tested on the stored (pre-update) value, so a crossing fires
   // on the channel's following update.
   always_comb begin
      ch_ok  = {1'b0, s1_ch} < NCH;
      v_cur  = v_q[s1_ch];
      r_cur  = r_q[s1_ch];
      syn_sh = s1_syn >>> I_SHIFT;
      q_sh   = v_cur >>> Q_SHIFT;
      sum    = SW'(v_cur) + SW'(syn_sh) + SW'(q_sh) * SW'(q_sh);
      v_sat  = W'(sat_w(64'(sum), W));
      at_th  = v_cur >= VTH;
      upd    = s1_valid && ch_ok;
      fire   = upd && r_cur == 4'd0 && at_th;
      v_nxt  = (r_cur != 4'd0 || at_th) ? VR : v_sat;
      r_nxt  = (r_cur != 4'd0) ? r_cur - 4'd1 : (at_th ? RF : 4'd0);
      ev_in  = '{ch: s1_ch, ts: ts};
      ev_pop = ev_ready && !ev_empty;
      ev_push = fire && (!ev_full || ev_pop);
      drop   = fire && !ev_push;
   end

`ifdef QIF_EVT_BACKPRESSURE_EN
   // Admit a request only if the FIFO can still absorb a spike from it and from
   // whatever S1 currently holds.
   assign i_ready = (ev_count < (AW+1)'(EV_DEPTH - 1)) ||
                    (ev_count == (AW+1)'(EV_DEPTH - 1) && !s1_valid);
`else
   assign i_ready = 1'b1;
`endif

   assign ev_valid = ev_count != '0;
   assign ev_ch    = ev_head.ch;
   assign ev_ts    = ev_head.ts;

   // Write-back and the next capture share an edge, so back-to-back updates to one
   // channel read the fresh value without forwarding.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < N_CH; i++) begin
            v_q[i] <= '0;
            r_q[i] <= '0;
         end
         s1_valid <= 1'b0;
         s1_ch    <= '0;
         s1_syn   <= '0;
         ts       <= '0;
         v_valid  <= 1'b0;
         v_ch     <= '0;
         v_mem    <= '0;
         v_spike  <= 1'b0;
         ev_drop  <= '0;
      end else begin
         ts       <= ts + TS_W'(1);
         s1_valid <= i_valid && i_ready;
         if (i_valid && i_ready) begin
            s1_ch  <= i_ch;
            s1_syn <= i_syn;
         end
         v_valid <= upd;
         if (upd) begin
            v_q[s1_ch] <= v_nxt;
            r_q[s1_ch] <= r_nxt;
            v_ch       <= s1_ch;
            v_mem      <= v_nxt;
            v_spike    <= fire;
         end
         if (drop && ev_drop != 8'hFF) ev_drop <= ev_drop + 8'd1;
      end
   end

   qif_evt_fifo #(
      .T     (ev_t),
      .DEPTH (EV_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (ev_push),
      .push_data (ev_in),
      .pop       (ev_pop),
      .head      (ev_head),
      .count     (ev_count),
      .full      (ev_full),
      .empty     (ev_empty)
   );

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb_qif_neuron_array: directed self-checking bench for qif_neuron_array (default and N_CH=3/I_SHIFT=0 instances).
module tb_qif_neuron_array;

   logic clk = 1'b0;
   logic rst_n = 1'b1;

   logic              a_valid = 1'b0, a_ready, a_vv, a_vsp, a_evv, a_evr = 1'b0;
   logic [1:0]        a_ch = '0, a_vch, a_evch;
   logic signed [7:0] a_syn = '0, a_vmem;
   logic [15:0]       a_evts;
   logic [7:0]        a_drop;

   logic              b_valid = 1'b0, b_ready, b_vv, b_vsp, b_evv, b_evr = 1'b0;
   logic [1:0]        b_ch = '0, b_vch, b_evch;
   logic signed [7:0] b_syn = '0, b_vmem;
   logic [15:0]       b_evts;
   logic [7:0]        b_drop;

   int n_cmp = 0;
   int n_bad = 0;
   int a_m[$], a_c[$], a_s[$], b_m[$], b_c[$], b_s[$], q0[$], q1[$];
   int e1[8]  = '{10, 21, 35, 61, -20, -20, -20, -1};
   int e2[3]  = '{-10, -16, -22};
   int e3m[4] = '{40, 127, 40, -20};
   int e3c[4] = '{2, 2, 0, 2};
   int e3s[4] = '{0, 0, 0, 1};
`ifdef QIF_EVT_BACKPRESSURE_EN
   int e5[4]  = '{0, 1, 2, 3};
`else
   int e5[4]  = '{1, 2, 3, 2};
`endif
   int prev_ts;

   always #5 clk = ~clk;

   qif_neuron_array u_dut (
      .clk (clk), .rst_n (rst_n),
      .i_valid (a_valid), .i_ready (a_ready), .i_ch (a_ch), .i_syn (a_syn),
      .v_valid (a_vv), .v_ch (a_vch), .v_mem (a_vmem), .v_spike (a_vsp),
      .ev_valid (a_evv), .ev_ready (a_evr), .ev_ch (a_evch), .ev_ts (a_evts), .ev_drop (a_drop)
   );

   qif_neuron_array #(.N_CH(3), .I_SHIFT(0)) u_n3 (
      .clk (clk), .rst_n (rst_n),
      .i_valid (b_valid), .i_ready (b_ready), .i_ch (b_ch), .i_syn (b_syn),
      .v_valid (b_vv), .v_ch (b_vch), .v_mem (b_vmem), .v_spike (b_vsp),
      .ev_valid (b_evv), .ev_ready (b_evr), .ev_ch (b_evch), .ev_ts (b_evts), .ev_drop (b_drop)
   );

   always @(negedge clk) begin
      if (a_vv) begin
         a_m.push_back(int'(a_vmem));
         a_c.push_back(int'(a_vch));
         a_s.push_back(int'(a_vsp));
      end
      if (b_vv) begin
         b_m.push_back(int'(b_vmem));
         b_c.push_back(int'(b_vch));
         b_s.push_back(int'(b_vsp));
      end
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      a_m.delete(); a_c.delete(); a_s.delete();
      b_m.delete(); b_c.delete(); b_s.delete();
      q0.delete(); q1.delete();
   endtask

   task automatic send(input bit u, input int c, input int s);
      int n = 0;
      if (u) begin b_ch = 2'(c); b_syn = 8'(s); b_valid = 1'b1; end
      else begin a_ch = 2'(c); a_syn = 8'(s); a_valid = 1'b1; end
      while (!(u ? b_ready : a_ready) && n < 20) begin
         @(posedge clk);
         #1 n++;
      end
      if (n == 20) chk("ready_timeout", 0, 1);
      else begin
         @(posedge clk);
         #1;
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pop(input bit u);
      if (u) b_evr = 1'b1;
      else a_evr = 1'b1;
      @(posedge clk);
      #1 a_evr = 1'b0;
      b_evr = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got 0 expected 1");
      $fatal(1);
   end

   initial begin
      do_reset();
      chk("rst_v_valid", a_vv, 0);
      chk("rst_v_ch", a_vch, 0);
      chk("rst_v_mem", a_vmem, 0);
      chk("rst_v_spike", a_vsp, 0);
      chk("rst_ev_valid", a_evv, 0);
      chk("rst_ev_drop", a_drop, 0);
      chk("rst_i_ready", a_ready, 1);

      for (int i = 0; i < 8; i++) send(0, 0, 40);
      drain();
      chk("s1_count", a_m.size(), 8);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("s1_mem%0d", i), a_m[i], e1[i]);
         chk($sformatf("s1_spk%0d", i), a_s[i], (i == 4) ? 1 : 0);
      end
      chk("s1_ev_valid", a_evv, 1);
      chk("s1_ev_ch", a_evch, 0);
      pop(0);
      chk("s1_ev_empty", a_evv, 0);

      do_reset();
      for (int i = 0; i < 8; i++) begin
         send(0, 0, 40);
         if (i < 3) send(0, 1, -40);
      end
      drain();
      foreach (a_m[i]) begin
         if (a_c[i] == 0) q0.push_back(a_m[i]);
         else q1.push_back(a_m[i]);
      end
      chk("il_ch0_cnt", q0.size(), 8);
      chk("il_ch1_cnt", q1.size(), 3);
      for (int i = 0; i < 8; i++) chk($sformatf("il_ch0_mem%0d", i), q0[i], e1[i]);
      for (int i = 0; i < 3; i++) chk($sformatf("il_ch1_mem%0d", i), q1[i], e2[i]);

      do_reset();
      send(1, 2, 40);
      send(1, 2, 100);
      send(1, 3, 100);
      send(1, 0, 40);
      send(1, 2, 5);
      drain();
      chk("n3_count", b_m.size(), 4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("n3_mem%0d", i), b_m[i], e3m[i]);
         chk($sformatf("n3_ch%0d", i), b_c[i], e3c[i]);
         chk($sformatf("n3_spk%0d", i), b_s[i], e3s[i]);
      end
      chk("n3_ev_valid", b_evv, 1);
      chk("n3_ev_ch", b_evch, 2);

      do_reset();
      send(1, 1, 40);
      rst_n = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b0;
      drain();
      chk("mid_rst_vcount", b_m.size(), 0);
      chk("mid_rst_v_valid", b_vv, 0);
      chk("mid_rst_v_ch", b_vch, 0);
      chk("mid_rst_v_mem", b_vmem, 0);
      chk("mid_rst_v_spike", b_vsp, 0);
      chk("mid_rst_ev_valid", b_evv, 0);
      send(1, 1, 40);
      drain();
      chk("mid_rst_after_cnt", b_m.size(), 1);
      chk("mid_rst_after_mem", b_m[0], 40);

      do_reset();
      for (int r = 0; r < 3; r++)
         for (int c = 0; c < 4; c++) send(0, c, 127);
      drain();
      chk("ovf_ev_valid", a_evv, 1);
      chk("ovf_head0", a_evch, 0);
`ifdef QIF_EVT_BACKPRESSURE_EN
      chk("ovf_ready_low", a_ready, 0);
      chk("ovf_drop", a_drop, 0);
`else
      chk("ovf_ready_high", a_ready, 1);
      for (int c = 0; c < 2; c++)
         for (int k = 0; k < 5; k++) send(0, c, 127);
      drain();
      chk("ovf_drop", a_drop, 2);
      chk("ovf_head_kept", a_evch, 0);
      for (int k = 0; k < 5; k++) send(0, 2, 127);
      a_evr = 1'b1;
      @(posedge clk);
      #1 a_evr = 1'b0;
      chk("full_pp_head", a_evch, 1);
      chk("full_pp_drop", a_drop, 2);
`endif
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("ovf_pop_valid%0d", i), a_evv, 1);
         chk($sformatf("ovf_pop_ch%0d", i), a_evch, e5[i]);
         if (i > 0 && i < 3) chk($sformatf("ovf_pop_ts%0d", i), a_evts, (prev_ts + 1) & 16'hFFFF);
         prev_ts = a_evts;
         pop(0);
      end
      chk("ovf_empty", a_evv, 0);
      chk("ovf_ready_end", a_ready, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
